// File: rtl/vga_timing_gen_if.sv
// Raster bus between vga_timing_gen (master) and its consumers (slave):
// pixel strobe and line-compare controls in, positions, pins and strobes out.
`timescale 1ns/1ps

interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          pix_en;
    logic [CW-1:0] posx;
    logic [CW-1:0] posy;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic [CW-1:0] irq_line;
    logic          irq_clr;
    logic          irq;

    modport master (
        input  pix_en, irq_line, irq_clr,
        output posx, posy, active, hsync, vsync, de,
               line_start, frame_start, irq
    );

    modport slave (
        output pix_en, irq_line, irq_clr,
        input  posx, posy, active, hsync, vsync, de,
               line_start, frame_start, irq
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel enable and delayed sync/DE pins.
// Optional line-compare interrupt built only when VTG_LINE_IRQ_EN is defined.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = 11,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] posx_q;
    logic [CW-1:0] posy_q;
    logic [CW-1:0] posx_nx;
    logic [CW-1:0] posy_nx;
    logic          line_end;
    logic          frame_end;
    logic          hs_nx;
    logic          vs_nx;
    logic          de_nx;
    logic          hs_cur;
    logic          vs_cur;
    logic          de_cur;
    logic          line_start_q;
    logic          frame_start_q;
    logic          hs_term;
    logic          vs_term;
    logic          de_term;

    always_comb begin
        line_end  = (posx_q == H_LAST);
        frame_end = line_end && (posy_q == V_LAST);
        posx_nx   = line_end ? '0 : posx_q + ONE;
        posy_nx   = posy_q;
        if (line_end) begin
            posy_nx = frame_end ? '0 : posy_q + ONE;
        end
        hs_nx = (int'(posx_nx) >= HS_START) && (int'(posx_nx) < HS_END);
        vs_nx = (int'(posy_nx) >= VS_START) && (int'(posy_nx) < VS_END);
        de_nx = (int'(posx_nx) < H_ACTIVE) && (int'(posy_nx) < V_ACTIVE);
    end

    // Sync/DE terms are registered from the next counter value so that, with
    // no extra delay, they line up with the posx/posy they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            posx_q        <= '0;
            posy_q        <= '0;
            hs_cur        <= 1'b0;
            vs_cur        <= 1'b0;
            de_cur        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vid.pix_en) begin
                posx_q        <= posx_nx;
                posy_q        <= posy_nx;
                hs_cur        <= hs_nx;
                vs_cur        <= vs_nx;
                de_cur        <= de_nx;
                line_start_q  <= line_end;
                frame_start_q <= frame_end;
            end
        end
    end

    if (PIPE_DELAY > 0) begin : g_pipe
        logic [PIPE_DELAY-1:0] hs_p;
        logic [PIPE_DELAY-1:0] vs_p;
        logic [PIPE_DELAY-1:0] de_p;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hs_p <= '0;
                vs_p <= '0;
                de_p <= '0;
            end else if (vid.pix_en) begin
                hs_p <= (hs_p << 1) | PIPE_DELAY'(hs_cur);
                vs_p <= (vs_p << 1) | PIPE_DELAY'(vs_cur);
                de_p <= (de_p << 1) | PIPE_DELAY'(de_cur);
            end
        end

        assign hs_term = hs_p[PIPE_DELAY-1];
        assign vs_term = vs_p[PIPE_DELAY-1];
        assign de_term = de_p[PIPE_DELAY-1];
    end else begin : g_nopipe
        assign hs_term = hs_cur;
        assign vs_term = vs_cur;
        assign de_term = de_cur;
    end

    assign vid.posx        = posx_q;
    assign vid.posy        = posy_q;
    assign vid.active      = (int'(posx_q) < H_ACTIVE) && (int'(posy_q) < V_ACTIVE);
    assign vid.hsync       = hs_term ~^ HS_POL;
    assign vid.vsync       = vs_term ~^ VS_POL;
    assign vid.de          = de_term;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

`ifdef VTG_LINE_IRQ_EN
    logic irq_q;

    // A match on the strobe that lands on posx = 0 beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (vid.pix_en && line_end && (posy_nx == vid.irq_line)) begin
            irq_q <= 1'b1;
        end else if (vid.irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign vid.irq = irq_q;
`else
    logic unused_irq;

    assign unused_irq = ^{vid.irq_line, vid.irq_clr};
    assign vid.irq    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameter sets share the stimulus; a strobe-count
// model checks every cycle, plus a vector table and directed corner sequences.
`timescale 1ns/1ps

module tb_vga_timing_gen;

`ifdef VTG_LINE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        act;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic        irq;
    } vid_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
        int d;
    } cfg_t;

    typedef struct {
        int   adv;
        int   x, y;
        logic hs, vs, de, ls, fs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        irq_clr;
    logic [10:0] irq_line;

    int   n_checks = 0;
    int   n_pass   = 0;
    cfg_t cfg[4];
    vid_t act_v[4];

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(11)) if_a ();
    vga_timing_gen_if #(.CW(11)) if_b ();
    vga_timing_gen_if #(.CW(11)) if_c ();
    vga_timing_gen_if #(.CW(11)) if_d ();

    assign if_a.pix_en = pix_en;  assign if_a.irq_clr = irq_clr;  assign if_a.irq_line = irq_line;
    assign if_b.pix_en = pix_en;  assign if_b.irq_clr = irq_clr;  assign if_b.irq_line = irq_line;
    assign if_c.pix_en = pix_en;  assign if_c.irq_clr = irq_clr;  assign if_c.irq_line = irq_line;
    assign if_d.pix_en = pix_en;  assign if_d.irq_clr = irq_clr;  assign if_d.irq_line = irq_line;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(104), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .PIPE_DELAY(2)
    ) dut_a (.clk(clk), .rst_n(rst_n), .vid(if_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .PIPE_DELAY(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .vid(if_b));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .PIPE_DELAY(5)
    ) dut_c (.clk(clk), .rst_n(rst_n), .vid(if_c));

    vga_timing_gen dut_d (.clk(clk), .rst_n(rst_n), .vid(if_d));

    assign act_v[0] = {if_a.posx, if_a.posy, if_a.active, if_a.hsync, if_a.vsync, if_a.de,
                       if_a.line_start, if_a.frame_start, if_a.irq};
    assign act_v[1] = {if_b.posx, if_b.posy, if_b.active, if_b.hsync, if_b.vsync, if_b.de,
                       if_b.line_start, if_b.frame_start, if_b.irq};
    assign act_v[2] = {if_c.posx, if_c.posy, if_c.active, if_c.hsync, if_c.vsync, if_c.de,
                       if_c.line_start, if_c.frame_start, if_c.irq};
    assign act_v[3] = {if_d.posx, if_d.posy, if_d.active, if_d.hsync, if_d.vsync, if_d.de,
                       if_d.line_start, if_d.frame_start, if_d.irq};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Raster position is a pure function of strobes since reset; the pins show
    // the position from d strobes earlier, deasserted until that history exists.
    function automatic vid_t model(cfg_t c, int k, bit strobe, bit irq);
        vid_t e;
        int ht, vt, x, y, j, xo, yo;
        bit hterm, vterm, dterm;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        x = k % ht;
        y = (k / ht) % vt;
        hterm = 1'b0; vterm = 1'b0; dterm = 1'b0;
        if (k - c.d >= 1) begin
            j  = k - c.d;
            xo = j % ht;
            yo = (j / ht) % vt;
            hterm = (xo >= c.ha + c.hfp) && (xo < c.ha + c.hfp + c.hsw);
            vterm = (yo >= c.va + c.vfp) && (yo < c.va + c.vfp + c.vsw);
            dterm = (xo < c.ha) && (yo < c.va);
        end
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.act = (x < c.ha) && (y < c.va);
        e.hs  = hterm ? c.hpol : !c.hpol;
        e.vs  = vterm ? c.vpol : !c.vpol;
        e.de  = dterm;
        e.ls  = strobe && (x == 0);
        e.fs  = strobe && (x == 0) && (y == 0);
        e.irq = irq;
        return e;
    endfunction

    int          k = 0;
    bit          strobe_m = 1'b0;
    bit          irq_m[4];
    bit          mon_en = 1'b0;
    bit          s_r, s_p, s_c;
    logic [10:0] s_l;

    always @(posedge clk) begin
        s_r = rst_n; s_p = pix_en; s_c = irq_clr; s_l = irq_line;
        if (!s_r) begin
            k = 0;
            strobe_m = 1'b0;
            for (int d = 0; d < 4; d++) irq_m[d] = 1'b0;
        end else begin
            strobe_m = s_p;
            if (s_p) k++;
            for (int d = 0; d < 4; d++) begin
                int ht, vt, x, y;
                ht = cfg[d].ha + cfg[d].hfp + cfg[d].hsw + cfg[d].hbp;
                vt = cfg[d].va + cfg[d].vfp + cfg[d].vsw + cfg[d].vbp;
                x = k % ht;
                y = (k / ht) % vt;
                if (IRQ_ON && s_p && x == 0 && y == int'(s_l)) irq_m[d] = 1'b1;
                else if (s_c) irq_m[d] = 1'b0;
            end
        end
        #2;
        if (mon_en) begin
            for (int d = 0; d < 4; d++)
                check($sformatf("model dut%0d k=%0d", d, k), act_v[d],
                      model(cfg[d], k, strobe_m, irq_m[d]));
        end
    end

    task automatic do_reset();
        pix_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    vec_t tbl[10];
    int   ls_t[$];

    initial begin
        cfg[0] = '{16, 2, 3, 3, 104, 2, 2, 4, 1'b0, 1'b0, 2};
        cfg[1] = '{8, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0};
        cfg[2] = '{16, 2, 3, 3, 6, 2, 1, 2, 1'b0, 1'b0, 5};
        cfg[3] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};

        // dut_b (12x6, active-high syncs, no delay), cumulative strobes from reset
        tbl[0] = '{0,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1,  1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{7,  8,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1,  9,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1,  10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1,  11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1,  0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{36, 0,  4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{12, 0,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{12, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; pix_en = 1'b0; irq_clr = 1'b0; irq_line = 11'd100;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset hsync dut_d", if_d.hsync, 1'b1);
        check("reset de dut_d", if_d.de, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < tbl[i].adv; j++) begin
                pix_en = 1'b1;
                @(negedge clk);
            end
            pix_en = 1'b0;
            check($sformatf("tbl%0d posx", i), if_b.posx, 11'(tbl[i].x));
            check($sformatf("tbl%0d posy", i), if_b.posy, 11'(tbl[i].y));
            check($sformatf("tbl%0d sync", i), {if_b.hsync, if_b.vsync, if_b.de},
                  {tbl[i].hs, tbl[i].vs, tbl[i].de});
            check($sformatf("tbl%0d strobes", i), {if_b.line_start, if_b.frame_start},
                  {tbl[i].ls, tbl[i].fs});
        end

        // Continuous strobes from reset: default hsync window, delayed DE, irq at line 100
        do_reset();
        for (int i = 1; i < 2400; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
            if (i == 657) check("dut_d hsync before 658", if_d.hsync, 1'b1);
            if (i == 658) check("dut_d hsync at 658", if_d.hsync, 1'b0);
            if (i == 753) check("dut_d hsync at 753", if_d.hsync, 1'b0);
            if (i == 754) check("dut_d hsync after 753", if_d.hsync, 1'b1);
            if (i == 24)  check("dut_c active at posx0", {if_c.active, if_c.de}, 2'b10);
            if (i == 28)  check("dut_c de at posx4", if_c.de, 1'b0);
            if (i == 29)  check("dut_c de at posx5", {if_c.posx, if_c.de}, {11'd5, 1'b1});
        end
        irq_clr = 1'b1;
        @(negedge clk);
        check("irq pos", {if_a.posx, if_a.posy}, {11'd0, 11'd100});
        check("irq set beats clr", if_a.irq, IRQ_ON);
        pix_en = 1'b0; irq_clr = 1'b0;
        @(negedge clk);
        check("irq sticky", if_a.irq, IRQ_ON);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq cleared", if_a.irq, 1'b0);

        // Reset mid-frame aborts the frame
        do_reset();
        for (int i = 0; i < 1210; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
        end
        pix_en = 1'b0;
        check("pre-reset pos", {if_a.posx, if_a.posy}, {11'd10, 11'd50});
        rst_n = 1'b0; pix_en = 1'b1;
        @(negedge clk);
        check("mid reset pos", {if_a.posx, if_a.posy}, 22'd0);
        check("mid reset pins", {if_a.hsync, if_a.vsync, if_a.de, if_a.frame_start}, 4'b1100);
        check("mid reset pins b", {if_b.hsync, if_b.vsync, if_b.de}, 3'b000);
        rst_n = 1'b1; pix_en = 1'b0;
        @(negedge clk);

        // Randomized strobes, clears, compare lines and occasional resets
        for (int i = 0; i < 8000; i++) begin
            pix_en  = ($urandom_range(0, 2) != 0);
            irq_clr = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 1999) != 0);
            if (i % 500 == 0) irq_line = 11'($urandom_range(0, 12));
            @(negedge clk);
        end
        irq_clr = 1'b0; rst_n = 1'b1;

        // One strobe in four: line_start of the default timing every 3200 clks
        do_reset();
        for (int i = 0; i < 9800; i++) begin
            @(negedge clk);
            if (if_d.line_start) ls_t.push_back(i);
            pix_en = (i % 4 == 0);
        end
        pix_en = 1'b0;
        check("line_start count", ls_t.size(), 3);
        if (ls_t.size() >= 3) begin
            check("line_start period 1", ls_t[1] - ls_t[0], 3200);
            check("line_start period 2", ls_t[2] - ls_t[1], 3200);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the graphics adapter. Replaces the hard-coded 640x480 horizontal/vertical counters in the adapter top level. It provides:
- programmable porch, sync and active lengths, with sync polarity per axis;
- a pixel-clock enable, so the block runs from the fast system clock;
- a configurable delay on sync/DE, to align them with screen-RAM and character-ROM read latency;
- frame and line strobes, and an optional line-compare interrupt.

The mode controllers (mtxt/ctxt/bitmap) consume `posx`/`posy`; the VGA pins consume the delayed `hsync`/`vsync`/`de`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VS_POL`, 0, asserted level of `vsync`
- `CW`, 11, counter width; must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL)
- `PIPE_DELAY`, 2, pixel-enable cycles of delay on `hsync`/`vsync`/`de`; legal range 0..7

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `pix_en`  in  1  pixel strobe; the raster advances only on cycles where it is high
- `posx`  out  CW  current pixel column, undelayed
- `posy`  out  CW  current line, undelayed
- `active`  out  1  undelayed: `posx` < H_ACTIVE and `posy` < V_ACTIVE
- `hsync`  out  1  delayed horizontal sync, at pin polarity
- `vsync`  out  1  delayed vertical sync, at pin polarity
- `de`  out  1  delayed data enable
- `line_start`  out  1  one-`clk` pulse when `posx` wraps to 0
- `frame_start`  out  1  one-`clk` pulse when `posx` and `posy` both wrap to 0
- `irq_line`  in  CW  line-compare value
- `irq_clr`  in  1  clears `irq`
- `irq`  out  1  sticky line-compare interrupt

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both counters count 0..TOTAL-1 and wrap to 0.
- Horizontal counter `posx`: advances on each `pix_en` cycle.
- Vertical counter `posy`: advances on the `pix_en` cycle where `posx` == H_TOTAL-1.
- Sync asserted ranges:
  - `hsync` while H_ACTIVE+H_FP ≤ `posx` < H_ACTIVE+H_FP+H_SYNC;
  - `vsync` while V_ACTIVE+V_FP ≤ `posy` < V_ACTIVE+V_FP+V_SYNC;
  - vsync changes only at line boundaries.
- Undelayed sync/DE terms feed a PIPE_DELAY-deep shift register that advances only on `pix_en`. With PIPE_DELAY = 0 they are registered from the counters and appear the same cycle as `posx`.
- Pin polarity: each output = `term XNOR POL`.
- `line_start` and `frame_start` are registered with the counter update, undelayed, and high for exactly one `clk`.
- `posx`/`posy` keep counting through blanking. Consumers gate on `active`.

## Timing
- Reset (`rst_n` low at a clk edge): `posx` = `posy` = 0; delay pipe filled with deasserted values; `hsync` = ~HS_POL, `vsync` = ~VS_POL; `de`, `line_start`, `frame_start`, `irq` = 0.
  - Reset mid-frame aborts the current frame. After reset deasserts, the first `pix_en` moves `posx` to 1. No `frame_start` is emitted for the aborted frame.
- Latency:
  - a sync/DE edge appears PIPE_DELAY `pix_en` strobes after the counter value that causes it;
  - `clk` cycles between strobes do not count toward the delay.
- `pix_en` low: all counters, pipe stages and outputs hold; strobes stay 0.
- Wrap at (H_TOTAL-1, V_TOTAL-1): on the next `pix_en`, both counters go to 0 and both `line_start` and `frame_start` pulse in the same cycle.
- `irq_line` ≥ V_TOTAL never matches.

## Configuration
- `VTG_LINE_IRQ_EN` defined:
  - `irq` sets on the `pix_en` cycle where `posy` becomes equal to `irq_line` at `posx` = 0;
  - `irq_clr` clears it on any `clk` edge;
  - set and clear in the same cycle: set wins.
- `VTG_LINE_IRQ_EN` undefined:
  - compare logic is removed and `irq` is tied 0;
  - `irq_line` and `irq_clr` are ignored;
  - the ports remain, so the top level is unchanged.

## Test plan
- Default parameters, `pix_en` high every cycle, reset then run 2 frames:
  - `hsync` low for 96 strobes starting at `posx` = 656+2 (PIPE_DELAY);
  - `vsync` low for lines 490–491;
  - `frame_start` period exactly 420000 strobes.
- `pix_en` high 1-in-4 cycles:
  - `line_start` every 3200 clks;
  - all outputs stable in the cycles between strobes.
- PIPE_DELAY = 0 vs 5:
  - `de` rising edge coincides with `posx` = 0 for 0;
  - with 5 it coincides with `posx` = 5, while `active` already rose at `posx` = 0.
- HS_POL = 1, VS_POL = 1, H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 1, V_TOTAL = 6:
  - `hsync` high only at `posx` 9–10 (PIPE_DELAY = 0);
  - `posx` wraps at 12; `posy` wraps at 6.
- `rst_n` low at `posx` = 300, `posy` = 200:
  - next cycle all counters 0, `hsync`/`vsync` inactive, `de` = 0, no `frame_start`.
- With `VTG_LINE_IRQ_EN`, `irq_line` = 100:
  - `irq` rises at `posy` = 100, `posx` = 0;
  - `irq_clr` asserted on that same cycle leaves `irq` = 1; asserted later, it clears to 0;
  - without the macro, `irq` stays 0.
